project1_assign_statement: RTL and testbench

//  3-input Boolean function block: output f is a pure combinational function of x,y,z,

---
 rtl/project1_assign_statement.sv | 59 +++++
 tb/tb_project1_assign_statement.sv | 119 +++++++++++
 2 files changed

// File: rtl/project1_assign_statement.sv
// project1_assign_statement: 3-input truth-table logic cell with a registered
// copy of its output, a rising-edge pulse and a saturating toggle counter.
// The combinational result f has no dependence on clk or rst and stays valid
// while rst is asserted. The monitoring registers treat the reset value 0 as
// the previous state of f.
module project1_assign_statement #(
    parameter logic [7:0] TRUTH_TABLE = 8'hCA,  // f = TRUTH_TABLE[{x,y,z}]
    parameter int         CNT_W       = 8       // width of toggle_cnt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             f,
    output logic             f_q,
    output logic             f_rise,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [2:0]       tt_index;
    logic             f_toggled;
    logic             cnt_at_max;
    logic [CNT_W-1:0] cnt_next;

    // x is the MSB of the table index and z is the LSB.
    // An X or Z on any input is passed through to f without masking.
    assign tt_index = {x, y, z};
    assign f        = TRUTH_TABLE[tt_index];

    // A toggle is counted when the sampled f differs from its registered copy.
    // The counter holds once every bit is set.
    assign f_toggled  = (f != f_q);
    assign cnt_at_max = (toggle_cnt == {CNT_W{1'b1}});

    // Next counter value: advance on a toggle and saturate at all-ones.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that leaves it unassigned infers a latch.
        cnt_next = toggle_cnt;
        if (f_toggled && !cnt_at_max) begin
            cnt_next = toggle_cnt + 1'b1;
        end
    end

    // Monitoring registers. Reset is asynchronous and takes effect between edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q        <= 1'b0;
            f_rise     <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments here make f_rise see the old f_q, not the value just written.
            f_q        <= f;
            f_rise     <= f & ~f_q;
            toggle_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_project1_assign_statement.sv
// Directed testbench for project1_assign_statement.
// Three instances share clk, rst and the inputs: the default mux table with an
// 8-bit counter, the default table with a 2-bit counter, and a 3-input XOR table.
module tb_project1_assign_statement;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x = 1'b0;
    logic       y = 1'b0;
    logic       z = 1'b0;

    logic       f_a, f_q_a, f_rise_a;
    logic [7:0] cnt_a;
    logic       f_b, f_q_b, f_rise_b;
    logic [1:0] cnt_b;
    logic       f_c, f_q_c, f_rise_c;
    logic [7:0] cnt_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    project1_assign_statement dut_a (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
        .f(f_a), .f_q(f_q_a), .f_rise(f_rise_a), .toggle_cnt(cnt_a)
    );

    project1_assign_statement #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
        .f(f_b), .f_q(f_q_b), .f_rise(f_rise_b), .toggle_cnt(cnt_b)
    );

    project1_assign_statement #(.TRUTH_TABLE(8'h96)) dut_c (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
        .f(f_c), .f_q(f_q_c), .f_rise(f_rise_c), .toggle_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed sweep results for xyz = 000..111.
    logic [7:0] mux_f = 8'b1100_1010;  // bit i = f for index i
    logic [7:0] xor_f = 8'b1001_0110;

    // Clocked sequence after reset release.
    logic [2:0] seq_xyz  [8] = '{3'b110, 3'b000, 3'b011, 3'b111, 3'b001, 3'b100, 3'b101, 3'b111};
    logic       seq_fq   [8] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
    logic       seq_rise [8] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
    logic [7:0] seq_cnt8 [8] = '{8'd1,   8'd2,   8'd3,   8'd3,   8'd3,   8'd4,   8'd4,   8'd5};
    logic [1:0] seq_cnt2 [8] = '{2'd1,   2'd2,   2'd3,   2'd3,   2'd3,   2'd3,   2'd3,   2'd3};

    initial begin
        // Assert reset before the first clock edge.
        #1 rst = 1'b1;

        // Sweep all input patterns 1 time unit apart while reset is held.
        for (int i = 0; i < 8; i++) begin
            {x, y, z} = 3'(i);
            #1;
            check($sformatf("mux_f[%0d]", i), 32'(f_a), 32'(mux_f[i]));
            check($sformatf("xor_f[%0d]", i), 32'(f_c), 32'(xor_f[i]));
            check($sformatf("rst_fq[%0d]", i), 32'(f_q_a), 32'd0);
            check($sformatf("rst_rise[%0d]", i), 32'(f_rise_a), 32'd0);
            check($sformatf("rst_cnt[%0d]", i), 32'(cnt_a), 32'd0);
        end

        // Keep reset high across a few edges with f=1; the registers must stay 0.
        {x, y, z} = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_fq", 32'(f_q_a), 32'd0);
        check("rst_hold_cnt", 32'(cnt_a), 32'd0);
        check("rst_hold_f", 32'(f_a), 32'd1);

        // Release reset away from the clock edge and run the sequence.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {x, y, z} = seq_xyz[i];
            @(posedge clk);
            #1;
            check($sformatf("seq_fq[%0d]", i), 32'(f_q_a), 32'(seq_fq[i]));
            check($sformatf("seq_rise[%0d]", i), 32'(f_rise_a), 32'(seq_rise[i]));
            check($sformatf("seq_cnt8[%0d]", i), 32'(cnt_a), 32'(seq_cnt8[i]));
            check($sformatf("seq_cnt2[%0d]", i), 32'(cnt_b), 32'(seq_cnt2[i]));
        end

        // A glitch between edges is not sampled: f stays 1 at the next edge.
        #2 {x, y, z} = 3'b000;
        #2 {x, y, z} = 3'b111;
        @(posedge clk);
        #1;
        check("glitch_fq", 32'(f_q_a), 32'd1);
        check("glitch_rise", 32'(f_rise_a), 32'd0);
        check("glitch_cnt8", 32'(cnt_a), 32'd5);

        // Asynchronous reset mid-cycle with the 2-bit counter saturated and f_q=1.
        check("pre_rst_cnt2", 32'(cnt_b), 32'd3);
        check("pre_rst_fq2", 32'(f_q_b), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_fq_a", 32'(f_q_a), 32'd0);
        check("async_cnt_a", 32'(cnt_a), 32'd0);
        check("async_fq_b", 32'(f_q_b), 32'd0);
        check("async_rise_b", 32'(f_rise_b), 32'd0);
        check("async_cnt_b", 32'(cnt_b), 32'd0);
        check("async_f_valid", 32'(f_a), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
